// File: rtl/key_sw_debounce_led.sv
// N-channel key/switch front end: 2-FF synchroniser, per-channel debounce,
// press/release pulses, LED driver (level or toggle) and a wrapping press counter.
module key_sw_debounce_led #(
  parameter int N_CH            = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACTIVE_LOW      = 1,
  parameter int LED_MODE        = 0,
  parameter int EVT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  key_sw,
  output logic [N_CH-1:0]  key_level,
  output logic [N_CH-1:0]  key_press,
  output logic [N_CH-1:0]  key_release,
  output logic [N_CH-1:0]  led,
  output logic [EVT_W-1:0] press_count
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  function automatic logic [EVT_W-1:0] popcount(input logic [N_CH-1:0] v);
    logic [EVT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < N_CH; i++) begin
      sum = sum + EVT_W'(v[i]);
    end
    return sum;
  endfunction

  logic [N_CH-1:0]  norm_s;
  logic [N_CH-1:0]  sync1_r;
  logic [N_CH-1:0]  sync2_r;
  logic [CNT_W-1:0] cnt_r      [N_CH];
  logic [CNT_W-1:0] cnt_next_s [N_CH];
  logic [N_CH-1:0]  level_next_s;
  logic [N_CH-1:0]  press_next_s;
  logic [N_CH-1:0]  release_next_s;
  logic [N_CH-1:0]  led_next_s;

  // 1 = pressed regardless of board wiring, so reset value 0 means "released"
  assign norm_s = (ACTIVE_LOW != 0) ? ~key_sw : key_sw;

  // Debounce decision per channel: any sample matching the accepted level restarts the count
  always_comb begin
    level_next_s   = key_level;
    press_next_s   = '0;
    release_next_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_next_s[i] = '0;
      if (sync2_r[i] == key_level[i]) begin
        cnt_next_s[i] = '0;
      end else if (cnt_r[i] != CNT_LAST) begin
        cnt_next_s[i] = cnt_r[i] + CNT_W'(1);
      end else begin
        level_next_s[i]   = sync2_r[i];
        press_next_s[i]   = sync2_r[i];
        release_next_s[i] = ~sync2_r[i];
        cnt_next_s[i]     = '0;
      end
    end
    if (LED_MODE == 0) begin
      led_next_s = level_next_s;
    end else begin
      led_next_s = led ^ press_next_s;
    end
  end

  // State and output registers; reset discards any in-flight debounce or pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r     <= '0;
      sync2_r     <= '0;
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      led         <= '0;
      press_count <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      sync1_r     <= norm_s;
      sync2_r     <= sync1_r;
      key_level   <= level_next_s;
      key_press   <= press_next_s;
      key_release <= release_next_s;
      led         <= led_next_s;
      press_count <= press_count + popcount(press_next_s);
      for (int i = 0; i < N_CH; i++) begin
        cnt_r[i] <= cnt_next_s[i];
      end
    end
  end

endmodule
